// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave taking 2-bit command + payload frames and returning read data on cmd 2'b11.
// Optional frame_err output is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_gen #(
  parameter int DATA_W = 8,
  localparam int RX_W = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [RX_W-1:0]   rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);
  localparam int CW = $clog2(RX_W + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ, READ_TX} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [RX_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic armed;
  logic last_bit;
  assign last_bit = count == CW'(RX_W - 1);
  // In READ_TX, count==0 means still waiting for tx_valid; otherwise it counts bits already on MISO.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      MISO <= 1'b0;
      armed <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= ss_n && (state inside {WRITE, READ, READ_TX});
`endif
      if (ss_n) begin
        state <= IDLE;
        count <= '0;
        rx_sr <= '0;
        tx_sr <= '0;
        MISO <= 1'b0;
        armed <= 1'b1;
      end else
        case (state)
          IDLE: state <= armed ? CHK_CMD : IDLE;
          CHK_CMD: begin
            rx_sr <= {rx_sr[RX_W-3:0], MOSI};
            count <= CW'(1);
            state <= MOSI ? READ : WRITE;
          end
          WRITE, READ: begin
            rx_sr <= {rx_sr[RX_W-3:0], MOSI};
            count <= last_bit ? '0 : count + 1'b1;
            if (last_bit) begin
              rx_data <= {rx_sr, MOSI};
              rx_valid <= 1'b1;
              state <= (state == READ && rx_sr[RX_W-3]) ? READ_TX : CHK_CMD;
            end
          end
          READ_TX:
            if (count == '0) begin
              if (tx_valid) begin
                tx_sr <= tx_data;
                MISO <= tx_data[DATA_W-1];
                count <= CW'(1);
              end
            end else if (count == CW'(DATA_W)) begin
              MISO <= 1'b0;
              count <= '0;
              state <= CHK_CMD;
            end else begin
              tx_sr <= tx_sr << 1;
              MISO <= tx_sr[DATA_W-2];
              count <= count + 1'b1;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: randomized SPI master driving spi_slave_gen; rx frames checked by a scoreboard monitor.
module tb_spi_slave_gen;
  localparam int DW = 8;
  localparam int RW = DW + 2;
  logic clk = 0, rst = 1, ss_n = 1, MOSI = 0, tx_valid = 0;
  logic MISO, rx_valid;
  logic [RW-1:0] rx_data;
  logic [DW-1:0] tx_data = '0;
  int checks = 0, errors = 0, cyc = 0;
  bit quiet = 1;
  typedef struct {logic [RW-1:0] d; int c;} exp_t;
  exp_t q[$];
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err;
  int fe_seen = 0, fe_exp = 0;
`endif
  spi_slave_gen #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", n, got, exp, cyc);
    end
  endtask
  // Monitor: every received frame must match the oldest expectation, in content and arrival cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      if (rx_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_spurious got %0h expected no frame at cycle %0d", rx_data, cyc);
        end else begin
          e = q.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("rx_cycle", cyc, e.c);
        end
      end
      if (quiet) chk("miso_idle", MISO, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) fe_seen++;
`endif
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ss_n = 1;
      MOSI = 1'($urandom);
    end
  endtask
  task automatic send_frame(input logic [RW-1:0] f, input int abort_at);
    if (ss_n) begin
      @(negedge clk);
      ss_n = 0;
    end
    for (int i = RW - 1; i >= 0; i--) begin
      @(negedge clk);
      tx_valid = 1'($urandom);
      tx_data = DW'($urandom);
      if (RW - 1 - i == abort_at) begin
        ss_n = 1;
        MOSI = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (abort_at > 0) fe_exp++;
`endif
        return;
      end
      MOSI = f[i];
      if (i == 0) q.push_back('{f, cyc + 1});
    end
  endtask
  task automatic read_tx(input logic [DW-1:0] v, input int waits, input int rst_at);
    repeat (waits) begin
      @(negedge clk);
      tx_valid = 0;
      tx_data = DW'($urandom);
    end
    @(negedge clk);
    tx_valid = 1;
    tx_data = v;
    quiet = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      @(negedge clk);
      tx_valid = 1'($urandom);
      tx_data = DW'($urandom);
      if (DW - 1 - i == rst_at) begin
        #2 rst = 0;
        #1;
        chk("rst_miso", MISO, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        quiet = 1;
        return;
      end
      chk("miso_bit", MISO, v[i]);
    end
    quiet = 1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] v;
    #2 rst = 0;
    #1;
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_miso", MISO, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    idle(2);
    send_frame(10'h0A5, RW);
    send_frame(10'h212, RW);
    send_frame(10'h300, RW);
    read_tx(8'h3C, 0, DW);
    v = DW'($urandom);
    send_frame({2'b11, DW'($urandom)}, RW);
    read_tx(v, 4, DW);
    send_frame(10'h0FF, 5);
    idle(2);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: send_frame({1'b0, 1'($urandom), DW'($urandom)}, RW);
        1: send_frame({2'b10, DW'($urandom)}, RW);
        2: begin
          v = DW'($urandom);
          send_frame({2'b11, DW'($urandom)}, RW);
          read_tx(v, $urandom_range(0, 5), DW);
        end
        default: send_frame({1'b0, 1'($urandom), DW'($urandom)}, $urandom_range(1, RW - 1));
      endcase
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    v = DW'($urandom);
    send_frame({2'b11, DW'($urandom)}, RW);
    read_tx(v, 1, 3);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (RW + 3) begin
      @(negedge clk);
      MOSI = 1'($urandom);
    end
    #1 chk("no_frame_before_ss_high", rx_data, 0);
    idle(1);
    send_frame(10'h1C3, RW);
    send_frame({2'b10, DW'($urandom)}, RW);
    idle(3);
    chk("rx_pending", q.size(), 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("frame_err_count", fe_seen, fe_exp);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits (legal range 4..32).
REQ-002 The block SHALL define derived width RX_W = DATA_W+2: 2 command bits followed by the payload.
REQ-003 The block SHALL have port clk, input, 1 bit: SPI serial clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port ss_n, input, 1 bit: slave select, active-low.
REQ-006 The block SHALL have port MOSI, input, 1 bit: serial data from the master, MSB first.
REQ-007 The block SHALL have port MISO, output, 1 bit: serial data to the master, MSB first.
REQ-008 The block SHALL have port rx_data, output, RX_W bits: the last complete received frame.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking a new rx_data.
REQ-010 The block SHALL have port tx_data, input, DATA_W bits: read payload to be returned to the master.
REQ-011 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid and may be loaded.

Function
REQ-012 The block SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ and READ_TX.
REQ-013 In any state, ss_n=1 at a rising edge SHALL force IDLE, clear the bit counter and discard any partial frame without pulsing rx_valid.
REQ-014 From IDLE, ss_n=0 SHALL move the FSM to CHK_CMD on the next edge.
REQ-015 In CHK_CMD, the FSM SHALL shift MOSI in as frame bit RX_W-1, set count=1, and go to READ if MOSI=1, otherwise to WRITE.
REQ-016 In WRITE and READ, the block SHALL shift MOSI in and increment count on every edge.
REQ-017 When count reaches RX_W, the full frame SHALL appear on rx_data with rx_valid=1 for exactly one cycle, starting the cycle after the last bit is sampled.
REQ-018 At frame end, WRITE, and READ with command 2'b10, SHALL return to CHK_CMD; back-to-back frames SHALL be accepted without ss_n deassertion.
REQ-019 At frame end, READ with command 2'b11 SHALL go to READ_TX.
REQ-020 In READ_TX, the block SHALL hold MISO=0 until tx_valid=1 is sampled, then load tx_data into the shift register.
REQ-021 From the cycle after the load, MISO SHALL present tx_data[DATA_W-1] down to tx_data[0], one bit per cycle, then the FSM SHALL return to CHK_CMD.
REQ-022 tx_valid SHALL be ignored outside READ_TX and after a load within the same READ_TX visit; tx_data SHALL be sampled only at the load edge.
REQ-023 MISO SHALL be 0 whenever the block is not shifting read data.
REQ-024 The bit counter SHALL be sized ceil(log2(RX_W+1)) and SHALL never wrap within a frame.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, count=0, rx_data=0, rx_valid=0, MISO=0 and clear the shift registers, including during an active transfer.
REQ-026 After reset release, the block SHALL require ss_n=1 for at least one edge before it accepts a new frame.

Configuration
REQ-027 With macro SPI_SLAVE_FRAME_ERR_EN defined, the block SHALL add output frame_err, 1 bit, reset 0.
REQ-028 With SPI_SLAVE_FRAME_ERR_EN defined, frame_err SHALL pulse for one cycle when ss_n rises during WRITE, READ or READ_TX before frame or payload completion.
REQ-029 Without SPI_SLAVE_FRAME_ERR_EN, the frame_err port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-030 Write test: DATA_W=8, ss_n=0, MOSI bits 0,0 then 8'hA5 -> rx_data=10'h0A5 with rx_valid high exactly one cycle after the 10th bit.
REQ-031 Read test: frame 2'b10+8'h12 -> rx_data=10'h212 and FSM returns to CHK_CMD; then frame 2'b11+8'h00 with tx_valid=1, tx_data=8'h3C -> MISO sequence 0,0,1,1,1,1,0,0.
REQ-032 Abort test: ss_n rises after 5 bits of a write -> no rx_valid, FSM in IDLE; with macro defined, frame_err pulses once.
REQ-033 Reset test: rst=0 asserted mid-READ_TX shift -> MISO=0, rx_valid=0 and state IDLE immediately, with no clk edge required.
REQ-034 Width test: DATA_W=16 with two back-to-back write frames under continuous ss_n=0 -> two rx_valid pulses 18 cycles apart, carrying the correct 18-bit words.
REQ-035 Handshake test: in READ_TX, tx_valid held low for 4 cycles -> MISO stays 0 and count is frozen; asserting tx_valid then starts the shift on the following cycle.
